// File: rtl/div_pkg.sv
// Shared definitions for the divider issue/result controller: opcodes, latency,
// divide-by-zero result and the sideband entry that travels beside the divider.
package div_pkg;

  localparam logic        OP_DIV       = 1'b0;
  localparam logic        OP_MOD       = 1'b1;
  localparam int          DIV_LATENCY  = 16;
  localparam logic [15:0] DBZ_QUOTIENT = 16'hFFFF;

  // Tag width carried by the sideband entry; the controller's TAG_W must not exceed it.
  localparam int          DIV_TAG_W    = 3;

  typedef struct packed {
    logic                 vld;
    logic                 op;
    logic                 dbz;
    logic [DIV_TAG_W-1:0] tag;
    logic [15:0]          dividend;
  } sb_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small register-based FIFO whose head always sits in entry 0, so the read
// data comes straight from a flop and reads as zero after reset.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    wr_idx;
  logic             do_push, do_pop;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned (no latch).
    mem_d   = mem_q;
    count_d = count_q;
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    wr_idx  = count_q - CW'(do_pop);

    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
    end
    if (do_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_idx == CW'(i)) mem_d[i] = wdata_i;
      end
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // NOTE: the storage is reset on purpose: it is only a few flops and the head must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign rdata_o = mem_q[0];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/result controller around the free-running pipelined divider: credit-limited
// issue, sideband pipe aligned with the divider, result select and output buffering.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int LATENCY    = DIV_LATENCY,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = DIV_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [15:0]      req_dividend,
  input  logic [15:0]      req_divisor,
  input  logic [TAG_W-1:0] req_tag,
  output logic [15:0]      div_dividend,
  output logic [15:0]      div_divisor,
  input  logic [15:0]      div_quotient,
  input  logic [15:0]      div_remainder,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_dbz
);

  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int RES_W = 16 + TAG_W + 1;

  logic             accept;
  sb_entry_t        sb_in;
  sb_entry_t        sb_q [LATENCY];
  sb_entry_t        sb_exit_q;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic [CW-1:0]    fifo_count;
  logic [15:0]      res_sel;
  logic [RES_W-1:0] fifo_wdata, fifo_rdata;
  logic             fifo_push, fifo_pop;

  // Credit check uses registered state only, so a same-cycle pop frees a slot one cycle later.
  assign req_ready = ({1'b0, inflight_q} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
  assign accept    = req_valid && req_ready;

  assign div_dividend = req_dividend;
  assign div_divisor  = req_divisor;

  always_comb begin
    sb_in.vld      = accept;
    sb_in.op       = req_op;
    sb_in.dbz      = (req_divisor == 16'd0);
    sb_in.tag      = DIV_TAG_W'(req_tag);
    sb_in.dividend = req_dividend;
  end

  // sb_exit_q is the stage that lines up with the divider's output register.
  always_ff @(posedge clk) begin
    sb_q[0] <= sb_in;
    for (int i = 1; i < LATENCY; i++) sb_q[i] <= sb_q[i-1];
    sb_exit_q <= sb_q[LATENCY-1];
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) sb_q[i].vld <= 1'b0;
      sb_exit_q.vld <= 1'b0;
    end
  end

  always_comb begin
    res_sel = (sb_exit_q.op == OP_MOD) ? div_remainder : div_quotient;
    if (sb_exit_q.dbz) begin
      res_sel = (sb_exit_q.op == OP_MOD) ? sb_exit_q.dividend : DBZ_QUOTIENT;
    end
  end

  assign fifo_push  = sb_exit_q.vld;
  assign fifo_wdata = {res_sel, TAG_W'(sb_exit_q.tag), sb_exit_q.dbz};
  assign fifo_pop   = res_valid && res_ready;

  always_comb begin
    inflight_d = inflight_q;
    case ({accept, fifo_push})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) inflight_q <= '0;
    else     inflight_q <= inflight_d;
  end

  sync_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .valid_o (res_valid),
    .count_o (fifo_count)
  );

  assign {res_data, res_tag, res_dbz} = fifo_rdata;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl with a behavioural pipelined divider,
// a directed vector table and hand-written back-pressure and reset sequences.
module tb_div_issue_ctrl;
  import div_pkg::*;

  localparam int LAT   = 16;
  localparam int DEPTH = 4;
  localparam int TW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_op;
  logic [15:0]   req_dividend, req_divisor;
  logic [TW-1:0] req_tag;
  logic [15:0]   div_dividend, div_divisor, div_quotient, div_remainder;
  logic          res_valid, res_ready, res_dbz;
  logic [15:0]   res_data;
  logic [TW-1:0] res_tag;

  always #5 clk = ~clk;

  div_issue_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .req_tag       (req_tag),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_tag       (res_tag),
    .res_dbz       (res_dbz)
  );

  // Divider model: operands captured at edge 0 appear between edges LAT and LAT+1.
  // Divide-by-zero yields arbitrary garbage so the controller override is visible.
  logic [15:0] dq [0:LAT];
  logic [15:0] dr [0:LAT];
  always @(posedge clk) begin
    dq[0] <= (div_divisor == 16'd0) ? 16'hDEAD : div_dividend / div_divisor;
    dr[0] <= (div_divisor == 16'd0) ? 16'hBEEF : div_dividend % div_divisor;
    for (int k = 1; k <= LAT; k++) begin
      dq[k] <= dq[k-1];
      dr[k] <= dr[k-1];
    end
  end
  assign div_quotient  = dq[LAT];
  assign div_remainder = dr[LAT];

  typedef struct {
    logic          op;
    logic [15:0]   a;
    logic [15:0]   b;
    logic [TW-1:0] tag;
    logic [15:0]   exp_data;
    logic          exp_dbz;
  } vec_t;

  typedef struct {
    logic [15:0]   data;
    logic [TW-1:0] tag;
    logic          dbz;
  } res_t;

  vec_t vecs [12];
  res_t exp_q [$];
  res_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   n_results = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compares every popped result against the expected queue, in order.
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (dut.fifo_push && (dut.fifo_count == 3'(DEPTH)) && !(res_valid && res_ready)) begin
        total++;
        bad++;
        $display("FAIL fifo_overflow: push into full result buffer at %0t", $time);
      end
      if (res_valid && res_ready) begin
        n_results++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got data %0h tag %0d, none expected", res_data, res_tag);
        end else begin
          mon_e = exp_q.pop_front();
          check("res_data", 32'(res_data), 32'(mon_e.data));
          check("res_tag",  32'(res_tag),  32'(mon_e.tag));
          check("res_dbz",  32'(res_dbz),  32'(mon_e.dbz));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic op, input logic [15:0] a, input logic [15:0] b,
                       input logic [TW-1:0] tag, input logic track,
                       input logic [15:0] ed, input logic edbz);
    int   n;
    res_t r;
    n            = 0;
    req_valid    = 1'b1;
    req_op       = op;
    req_dividend = a;
    req_divisor  = b;
    req_tag      = tag;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: req_ready stayed 0 for %0d cycles", n);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (track) begin
        r.data = ed;
        r.tag  = tag;
        r.dbz  = edbz;
        exp_q.push_back(r);
      end
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      #2;
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   acc, nr0, seen;
    logic rdy;
    res_t r;
    logic [15:0] a, b, ed;
    logic op;

    vecs[0]  = '{OP_DIV, 16'd100,   16'd7,     3'd0, 16'd14,    1'b0};
    vecs[1]  = '{OP_MOD, 16'd100,   16'd7,     3'd1, 16'd2,     1'b0};
    vecs[2]  = '{OP_DIV, 16'd1234,  16'd0,     3'd2, 16'hFFFF,  1'b1};
    vecs[3]  = '{OP_MOD, 16'd1234,  16'd0,     3'd3, 16'd1234,  1'b1};
    vecs[4]  = '{OP_DIV, 16'd65535, 16'd1,     3'd4, 16'd65535, 1'b0};
    vecs[5]  = '{OP_MOD, 16'd65535, 16'd1,     3'd5, 16'd0,     1'b0};
    vecs[6]  = '{OP_DIV, 16'd65535, 16'd65535, 3'd6, 16'd1,     1'b0};
    vecs[7]  = '{OP_MOD, 16'd65535, 16'd65535, 3'd7, 16'd0,     1'b0};
    vecs[8]  = '{OP_DIV, 16'd0,     16'd5,     3'd0, 16'd0,     1'b0};
    vecs[9]  = '{OP_MOD, 16'd0,     16'd5,     3'd1, 16'd0,     1'b0};
    vecs[10] = '{OP_DIV, 16'd5,     16'd65535, 3'd2, 16'd0,     1'b0};
    vecs[11] = '{OP_MOD, 16'd5,     16'd65535, 3'd3, 16'd5,     1'b0};

    rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_dividend = '0;
    req_divisor = '0; req_tag = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_res_valid", 32'(res_valid), 32'd0);
    check("reset_res_data",  32'(res_data),  32'd0);
    check("reset_res_tag",   32'(res_tag),   32'd0);
    check("reset_res_dbz",   32'(res_dbz),   32'd0);

    // Single DIV: result first visible after edge LAT+1.
    @(negedge clk);
    issue(OP_DIV, 16'd100, 16'd7, 3'd3, 1'b1, 16'd14, 1'b0);
    repeat (16) @(negedge clk);
    #1;
    check("single_not_early", 32'(res_valid), 32'd0);
    @(negedge clk);
    #1;
    check("single_valid", 32'(res_valid), 32'd1);
    check("single_data",  32'(res_data),  32'd14);
    check("single_tag",   32'(res_tag),   32'd3);
    check("single_dbz",   32'(res_dbz),   32'd0);
    @(negedge clk);
    res_ready = 1'b1;
    wait_drain("single_drain");

    // Directed table: DIV/MOD, divide-by-zero and boundary operands, in issue order.
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, 1'b1, vecs[i].exp_data, vecs[i].exp_dbz);
    end
    wait_drain("table_drain");

    // Back-pressure: write-back stalled while requests are offered every cycle.
    @(negedge clk);
    res_ready = 1'b0;
    acc = 0;
    nr0 = n_results;
    for (int c = 0; c < 30; c++) begin
      req_valid    = 1'b1;
      req_op       = vecs[acc].op;
      req_dividend = vecs[acc].a;
      req_divisor  = vecs[acc].b;
      req_tag      = vecs[acc].tag;
      rdy          = req_ready;
      @(posedge clk);
      if (rdy) begin
        r.data = vecs[acc].exp_data;
        r.tag  = vecs[acc].tag;
        r.dbz  = vecs[acc].exp_dbz;
        exp_q.push_back(r);
        acc++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    #1;
    check("bp_accepted",  32'(acc),       32'd4);
    check("bp_req_ready", 32'(req_ready), 32'd0);
    check("bp_res_valid", 32'(res_valid), 32'd1);
    check("bp_head_data", 32'(res_data),  32'(vecs[0].exp_data));
    repeat (5) @(negedge clk);
    #1;
    check("bp_hold_data",  32'(res_data),  32'(vecs[0].exp_data));
    check("bp_hold_tag",   32'(res_tag),   32'(vecs[0].tag));
    check("bp_hold_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    res_ready = 1'b1;
    wait_drain("bp_drain");
    check("bp_count", 32'(n_results - nr0), 32'd4);

    // Sustained issue with write-back always ready.
    nr0 = n_results;
    for (int i = 0; i < 20; i++) begin
      a  = 16'(i * 1000);
      b  = 16'(i + 1);
      op = i[0];
      ed = op ? (a % b) : (a / b);
      issue(op, a, b, 3'(i), 1'b1, ed, 1'b0);
    end
    wait_drain("tp_drain");
    check("tp_count", 32'(n_results - nr0), 32'd20);

    // Reset mid-flight at edge 8: in-flight results must be discarded.
    issue(OP_DIV, 16'd900, 16'd9, 3'd1, 1'b0, 16'd0, 1'b0);
    issue(OP_MOD, 16'd901, 16'd9, 3'd2, 1'b0, 16'd0, 1'b0);
    issue(OP_DIV, 16'd902, 16'd0, 3'd3, 1'b0, 16'd0, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data",  32'(res_data),  32'd0);
    check("rst_res_tag",   32'(res_tag),   32'd0);
    check("rst_res_dbz",   32'(res_dbz),   32'd0);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      #1;
      if (res_valid) seen++;
    end
    check("rst_discard", 32'(seen), 32'd0);
    @(negedge clk);
    issue(OP_DIV, 16'd5000, 16'd7, 3'd5, 1'b1, 16'd714, 1'b0);
    wait_drain("rst_recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
